// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency byte-masked RAM plus a small MMIO window
// holding a cycle counter, a store counter, a scratch register and a sticky error flag.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 5,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        mem_err
);

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  localparam logic [31:0] RAM_BYTES = 32'(WORDS * 8);

  function automatic logic [63:0] lane_merge(input logic [63:0] old_w,
                                             input logic [63:0] new_w,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0] mem_q [WORDS];
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] stores_q, stores_d;
  logic [63:0] scratch_q, scratch_d;
  logic        err_q, err_d;

  logic                  aligned, ram_hit, mmio_hit, store_req;
  logic                  ram_wr, scr_wr, sts_wr, bad_st, commit;
  logic [31:0]           mmio_off;
  logic [1:0]            reg_sel;
  logic [DEPTH_LOG2-1:0] widx;
  logic [63:0]           ram_word_d;

  // Address decode; the offset subtraction keeps the window test wrap-safe.
  always_comb begin
    aligned   = (addr[2:0] == 3'd0);
    ram_hit   = (addr < RAM_BYTES);
    mmio_off  = addr - MMIO_BASE;
    mmio_hit  = (mmio_off < 32'd32) && !ram_hit;
    reg_sel   = addr[4:3];
    widx      = addr[DEPTH_LOG2+2:3];
    store_req = wr_en && (wmask != 8'd0);
    ram_wr    = store_req && aligned && ram_hit;
    scr_wr    = store_req && aligned && mmio_hit && (reg_sel == 2'd2);
    sts_wr    = store_req && aligned && mmio_hit && (reg_sel == 2'd3);
    bad_st    = store_req && !(aligned && (ram_hit || mmio_hit));
    commit    = ram_wr || scr_wr || sts_wr;
  end

  always_comb begin
    cycle_d    = cycle_q + 64'd1;
    stores_d   = (commit && !(&stores_q)) ? stores_q + 64'd1 : stores_q;
    scratch_d  = scr_wr ? lane_merge(scratch_q, wdata, wmask) : scratch_q;
    ram_word_d = lane_merge(mem_q[widx], wdata, wmask);
    // A new error outranks a write-1-to-clear landing on the same edge.
    if (bad_st)                            err_d = 1'b1;
    else if (sts_wr && wmask[0] && wdata[0]) err_d = 1'b0;
    else                                   err_d = err_q;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      cycle_q   <= '0;
      stores_q  <= '0;
      scratch_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      stores_q  <= stores_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (ram_wr) begin
      mem_q[widx] <= ram_word_d;
    end
  end

  // Reads see pre-edge state, so a same-word store shows up one cycle later.
  always_comb begin
    rdata = '0;
    if (aligned) begin
      if (ram_hit) begin
        rdata = mem_q[widx];
      end else if (mmio_hit) begin
        case (reg_sel)
          2'd0:    rdata = cycle_q;
          2'd1:    rdata = stores_q;
          2'd2:    rdata = scratch_q;
          default: rdata = {63'b0, err_q};
        endcase
      end
    end
  end

  assign mem_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner cases, and a
// randomized run against a behavioural memory-map model.
module tb_dmem_responder;

  localparam logic [31:0] M = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] addr;
  logic        wr_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [63:0] rdata;
  logic        mem_err;

  dmem_responder #(.DEPTH_LOG2(5), .MMIO_BASE(M)) dut (
    .clk(clk), .nrst(nrst), .addr(addr), .wr_en(wr_en),
    .wdata(wdata), .wmask(wmask), .rdata(rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [63:0] m_ram [32];
  logic [63:0] m_cyc, m_st, m_scr;
  logic        m_err;

  logic [63:0] act_rd;
  logic        act_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = '0;
    m_cyc = '0; m_st = '0; m_scr = '0; m_err = 1'b0;
  endtask

  function automatic logic [63:0] model_read(input logic [31:0] a);
    if (a % 8 != 0) return 64'd0;
    if (a < 256) return m_ram[a / 8];
    if (a >= M && a < M + 32) begin
      case ((a - M) / 8)
        0: return m_cyc;
        1: return m_st;
        2: return m_scr;
        default: return {63'b0, m_err};
      endcase
    end
    return 64'd0;
  endfunction

  function automatic logic [63:0] apply_lanes(input logic [63:0] w, input logic [63:0] d,
                                              input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    return w;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic we, input logic [63:0] d,
                            input logic [7:0] m);
    m_cyc = m_cyc + 1;
    if (we && m != 0) begin
      if (a % 8 != 0 || !(a < 256 || (a >= M && a < M + 32))) begin
        m_err = 1'b1;
      end else begin
        if (a < 256) begin
          m_ram[a / 8] = apply_lanes(m_ram[a / 8], d, m);
          if (m_st != '1) m_st = m_st + 1;
        end else if ((a - M) / 8 == 2) begin
          m_scr = apply_lanes(m_scr, d, m);
          if (m_st != '1) m_st = m_st + 1;
        end else if ((a - M) / 8 == 3) begin
          if (m[0] && d[0]) m_err = 1'b0;
          if (m_st != '1) m_st = m_st + 1;
        end
      end
    end
  endtask

  // Called at posedge+1; samples outputs mid-cycle, clocks once, updates the model.
  task automatic step(input logic [31:0] a, input logic we, input logic [63:0] d,
                      input logic [7:0] m);
    addr = a; wr_en = we; wdata = d; wmask = m;
    #3;
    act_rd = rdata;
    act_err = mem_err;
    @(posedge clk);
    model_edge(a, we, d, m);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [63:0] d;
    logic [7:0]  m;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [24];

  initial begin
    vt[0]  = '{32'h08,     1, 64'h1122334455667788, 8'hFF, 64'h0, 0};
    vt[1]  = '{32'h08,     1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h1122334455667788, 0};
    vt[2]  = '{32'h08,     0, 64'h0,                8'h00, 64'h11223344AAAAAAAA, 0};
    vt[3]  = '{M + 8,      0, 64'h0,                8'h00, 64'd2, 0};
    vt[4]  = '{32'h10,     1, 64'h5,                8'hFF, 64'h0, 0};
    vt[5]  = '{32'h10,     0, 64'h0,                8'h00, 64'h5, 0};
    vt[6]  = '{32'h0C,     1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 0};
    vt[7]  = '{32'h08,     0, 64'h0,                8'h00, 64'h11223344AAAAAAAA, 1};
    vt[8]  = '{M + 32'h18, 0, 64'h0,                8'h00, 64'h1, 1};
    vt[9]  = '{M + 32'h18, 1, 64'h1,                8'h01, 64'h1, 1};
    vt[10] = '{M + 32'h18, 0, 64'h0,                8'h00, 64'h0, 0};
    vt[11] = '{32'h2000,   0, 64'h0,                8'h00, 64'h0, 0};
    vt[12] = '{32'h0C,     0, 64'h0,                8'h00, 64'h0, 0};
    vt[13] = '{M + 32'h10, 1, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 0};
    vt[14] = '{M + 32'h10, 1, 64'h0,                8'hF0, 64'hDEADBEEFCAFEF00D, 0};
    vt[15] = '{M + 32'h10, 0, 64'h0,                8'h00, 64'h00000000CAFEF00D, 0};
    vt[16] = '{32'h2000,   1, 64'h1234,             8'h01, 64'h0, 0};
    vt[17] = '{32'h20,     1, 64'h77,               8'h00, 64'h0, 1};
    vt[18] = '{32'h20,     0, 64'h0,                8'h00, 64'h0, 1};
    vt[19] = '{M + 8,      0, 64'h0,                8'h00, 64'd6, 1};
    vt[20] = '{M,          1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'd20, 1};
    vt[21] = '{M,          0, 64'h0,                8'h00, 64'd21, 1};
    vt[22] = '{M + 8,      1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'd6, 1};
    vt[23] = '{M + 8,      0, 64'h0,                8'h00, 64'd6, 1};
  end

  initial begin
    logic [31:0] a;
    logic        we;
    logic [63:0] d, exp_rd;
    logic [7:0]  m;
    logic        exp_err;
    logic [31:0] unm [5];

    nrst = 1'b1; addr = '0; wr_en = 1'b0; wdata = '0; wmask = '0;
    unm[0] = 32'h100; unm[1] = 32'h2000; unm[2] = M - 8; unm[3] = M + 32; unm[4] = 32'hFFFF_FFF8;
    model_reset();

    // Stores while held in reset are dropped and everything reads zero
    repeat (2) @(posedge clk);
    #1;
    addr = 32'h08; wr_en = 1'b1; wdata = 64'h1122334455667788; wmask = 8'hFF;
    @(posedge clk); #1;
    check("rst_ram_rd", rdata, 64'h0);
    check("rst_err", {63'b0, mem_err}, 64'h0);
    addr = M;
    #1;
    check("rst_cycle_rd", rdata, 64'h0);
    addr = 32'h0C; wr_en = 1'b0;
    #1;

    // Release away from the edge; row 0's edge is the first one out of reset
    nrst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(vt[i].a, vt[i].we, vt[i].d, vt[i].m);
      check($sformatf("vec%0d_rd", i), act_rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), {63'b0, act_err}, {63'b0, vt[i].exp_err});
    end

    // Mid-operation reset: clears RAM, registers and err without a clock edge
    step(32'h18, 1'b1, 64'hCAFE, 8'hFF);
    step(M + 32'h10, 1'b1, 64'hBEEF, 8'hFF);
    #1;
    nrst = 1'b1;
    addr = 32'h18; wr_en = 1'b0;
    #1;
    check("mid_rst_ram", rdata, 64'h0);
    check("mid_rst_err", {63'b0, mem_err}, 64'h0);
    addr = M + 32'h10;
    #1;
    check("mid_rst_scratch", rdata, 64'h0);
    addr = M;
    #1;
    check("mid_rst_cycle", rdata, 64'h0);
    @(posedge clk); #1;
    check("mid_rst_hold", rdata, 64'h0);
    nrst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0: a = 32'($urandom_range(0, 31)) * 8;
        1: a = 32'($urandom_range(0, 31)) * 8 + 32'($urandom_range(1, 7));
        2, 3: a = M + 32'($urandom_range(0, 3)) * 8;
        4: a = M + 32'($urandom_range(0, 3)) * 8 + 32'($urandom_range(1, 7));
        default: a = unm[$urandom_range(0, 4)];
      endcase
      we = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      exp_rd = model_read(a);
      exp_err = m_err;
      step(a, we, d, m);
      check($sformatf("rnd%0d_rd@%08h", k, a), act_rd, exp_rd);
      check($sformatf("rnd%0d_err", k), {63'b0, act_err}, {63'b0, exp_err});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
